// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter register and IDLE/ISSUE/CAPTURE/DONE fetch sequencer.
// Define PC_BOUND_CHECK_EN to flag targets at or beyond PROG_LEN through err.
module pc_fetch_ctrl #(
  parameter int D          = 12,
  parameter int START_ADDR = 0,
  parameter int PROG_LEN   = 4096,
  parameter int CW         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          halt,
  input  logic [D-1:0]  target,
  output logic [D-1:0]  pc,
  output logic          pc_valid,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] instr_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  localparam logic [D-1:0]  START_PC = D'(START_ADDR);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t state;
  logic   armed;
  logic   out_of_range;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

`ifdef PC_BOUND_CHECK_EN
  assign out_of_range = (32'(target) >= 32'(PROG_LEN));
`else
  logic unused_prog_len;
  assign out_of_range    = 1'b0;
  assign unused_prog_len = (PROG_LEN != 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= START_PC;
      pc_valid  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      instr_cnt <= '0;
      armed     <= 1'b0;
    end else if (start) begin
      // start re-arms from any state; in ISSUE/CAPTURE this aborts and drops the pending target
      state     <= IDLE;
      pc        <= START_PC;
      pc_valid  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      instr_cnt <= '0;
      armed     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (armed) begin
            armed    <= 1'b0;
            state    <= ISSUE;
            pc_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (halt) begin
            state     <= DONE;
            pc_valid  <= 1'b0;
            done      <= 1'b1;
            instr_cnt <= sat_inc(instr_cnt);
          end else if (!stall) begin
            state    <= CAPTURE;
            pc_valid <= 1'b0;
          end
        end
        CAPTURE: begin
          instr_cnt <= sat_inc(instr_cnt);
          if (out_of_range) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            pc       <= target;
            state    <= ISSUE;
            pc_valid <= 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
